// File: rtl/mcpu_pkg.sv
// mcpu_pkg: shared state, opcode, funct, ALU and mux-select encodings for the MCPU
package mcpu_pkg;

    typedef enum logic [4:0] {
        S_IF       = 5'd0,
        S_ID       = 5'd1,
        S_MEM_ADDR = 5'd2,
        S_MEM_RD   = 5'd3,
        S_MEM_WB   = 5'd4,
        S_MEM_WR   = 5'd5,
        S_R_EXE    = 5'd6,
        S_R_WB     = 5'd7,
        S_BEQ      = 5'd8,
        S_BNE      = 5'd9,
        S_J        = 5'd10,
        S_I_EXE    = 5'd11,
        S_I_WB     = 5'd12,
        S_JAL      = 5'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_XOR = 6'b100110;
    localparam logic [5:0] FN_NOR = 6'b100111;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_SRL = 6'b000010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_XOR = 3'b011;
    localparam logic [2:0] ALU_NOR = 3'b100;
    localparam logic [2:0] ALU_SRL = 3'b101;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] DST_RT = 2'b00;
    localparam logic [1:0] DST_RD = 2'b01;
    localparam logic [1:0] DST_RA = 2'b10;

    localparam logic [1:0] M2R_ALU = 2'b00;
    localparam logic [1:0] M2R_MDR = 2'b01;
    localparam logic [1:0] M2R_PC  = 2'b10;

    localparam logic [1:0] SRCB_RT   = 2'b00;
    localparam logic [1:0] SRCB_4    = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_BOFS = 2'b11;

    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;

endpackage

// File: rtl/mcpu_ctrl_alu_op_decode.sv
// alu_op_decode: selects the ALU operation for the current control state
module alu_op_decode
    import mcpu_pkg::*;
(
    input  state_t     state,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output logic [2:0] alu_op,
    output logic       funct_ok
);

    logic [2:0] r_op;

    // map an R-type funct to its ALU code; unknown functs fall back to ADD and are flagged
    always_comb begin
        funct_ok = 1'b1;
        r_op     = ALU_ADD;
        case (funct)
            FN_ADD:  r_op = ALU_ADD;
            FN_SUB:  r_op = ALU_SUB;
            FN_AND:  r_op = ALU_AND;
            FN_OR:   r_op = ALU_OR;
            FN_XOR:  r_op = ALU_XOR;
            FN_NOR:  r_op = ALU_NOR;
            FN_SLT:  r_op = ALU_SLT;
            FN_SRL:  r_op = ALU_SRL;
            default: funct_ok = 1'b0;
        endcase
    end

    // choose the operation each state needs; idle states drive AND (all zeros)
    always_comb begin
        alu_op = ALU_AND;
        case (state)
            S_IF, S_ID, S_MEM_ADDR: alu_op = ALU_ADD;
            S_R_EXE:                alu_op = r_op;
            S_BEQ, S_BNE:           alu_op = ALU_SUB;
            S_I_EXE:                alu_op = (op == OP_SLTI) ? ALU_SLT : ALU_ADD;
            default:                alu_op = ALU_AND;
        endcase
    end

endmodule

// File: rtl/mcpu_ctrl.sv
// mcpu_ctrl: multi-cycle MCPU control FSM sequencing fetch, decode, execute, memory and write-back
module mcpu_ctrl
    import mcpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst_in,
    input  logic        zero,
    input  logic        MIO_ready,
    output logic        PC_en,
    output logic        IorD,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        RegWrite,
    output logic        CPU_MIO,
    output logic [1:0]  RegDst,
    output logic [1:0]  MemtoReg,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  PCSource,
    output logic [2:0]  ALU_operation,
    output logic [4:0]  state_out
);

    state_t     state, nxt;
    logic [5:0] op, funct;
    logic       funct_ok;
    logic       pc_en, ir_wr, reg_wr, mem_wr, mem_rd, mio;
    logic       unused_bits;

    assign op          = inst_in[31:26];
    assign funct       = inst_in[5:0];
    assign unused_bits = ^inst_in[25:6];
    assign state_out   = state;

    alu_op_decode u_alu_op_decode (
        .state    (state),
        .op       (op),
        .funct    (funct),
        .alu_op   (ALU_operation),
        .funct_ok (funct_ok)
    );

    // state register; reset returns to fetch without waiting for a clock edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_IF;
        else
            state <= nxt;
    end

    // next state: decode dispatch, memory-ready stalls, everything else falls back to fetch
    always_comb begin
        nxt = S_IF;
        case (state)
            S_IF:       nxt = MIO_ready ? S_ID : S_IF;
            S_ID: begin
                case (op)
                    OP_LW, OP_SW:     nxt = S_MEM_ADDR;
                    OP_RTYPE:         nxt = S_R_EXE;
                    OP_BEQ:           nxt = S_BEQ;
                    OP_BNE:           nxt = S_BNE;
                    OP_J:             nxt = S_J;
                    OP_JAL:           nxt = S_JAL;
                    OP_ADDI, OP_SLTI: nxt = S_I_EXE;
                    default:          nxt = S_IF;
                endcase
            end
            S_MEM_ADDR: nxt = (op == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   nxt = MIO_ready ? S_MEM_WB : S_MEM_RD;
            S_MEM_WR:   nxt = MIO_ready ? S_IF : S_MEM_WR;
            S_R_EXE:    nxt = S_R_WB;
            S_I_EXE:    nxt = S_I_WB;
            default:    nxt = S_IF;
        endcase
    end

    // datapath controls decoded from the current state plus the ready and zero flags
    always_comb begin
        pc_en    = 1'b0;
        ir_wr    = 1'b0;
        reg_wr   = 1'b0;
        mem_wr   = 1'b0;
        mem_rd   = 1'b0;
        mio      = 1'b0;
        IorD     = 1'b0;
        RegDst   = DST_RT;
        MemtoReg = M2R_ALU;
        ALUSrcA  = 1'b0;
        ALUSrcB  = SRCB_RT;
        PCSource = PCS_ALU;
        case (state)
            S_IF: begin
                mem_rd  = 1'b1;
                mio     = 1'b1;
                ALUSrcB = SRCB_4;
                ir_wr   = MIO_ready;
                pc_en   = MIO_ready;
            end
            S_ID:       ALUSrcB = SRCB_BOFS;
            S_MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
            end
            S_MEM_RD: begin
                mem_rd = 1'b1;
                mio    = 1'b1;
                IorD   = 1'b1;
            end
            S_MEM_WB: begin
                reg_wr   = 1'b1;
                MemtoReg = M2R_MDR;
            end
            S_MEM_WR: begin
                mem_wr = 1'b1;
                mio    = 1'b1;
                IorD   = 1'b1;
            end
            S_R_EXE:    ALUSrcA = 1'b1;
            S_R_WB: begin
                reg_wr = funct_ok;
                RegDst = DST_RD;
            end
            S_BEQ, S_BNE: begin
                ALUSrcA  = 1'b1;
                PCSource = PCS_ALUOUT;
                pc_en    = zero ^ (state == S_BNE);
            end
            S_J: begin
                pc_en    = 1'b1;
                PCSource = PCS_JUMP;
            end
            S_JAL: begin
                pc_en    = 1'b1;
                PCSource = PCS_JUMP;
                reg_wr   = 1'b1;
                RegDst   = DST_RA;
                MemtoReg = M2R_PC;
            end
            S_I_EXE: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
            end
            S_I_WB:     reg_wr = 1'b1;
            default:    ;
        endcase
    end

    assign PC_en    = pc_en  & ~rst;
    assign IRWrite  = ir_wr  & ~rst;
    assign RegWrite = reg_wr & ~rst;
    assign MemWrite = mem_wr & ~rst;
    assign MemRead  = mem_rd & ~rst;
    assign CPU_MIO  = mio    & ~rst;

endmodule

// File: tb/tb_mcpu_ctrl.sv
// tb_mcpu_ctrl: randomized and directed checks of mcpu_ctrl against a path-based instruction model
module tb_mcpu_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] inst_in = '0;
    logic        zero = 1'b0;
    logic        MIO_ready = 1'b0;
    logic        PC_en, IorD, MemRead, MemWrite, IRWrite, RegWrite, CPU_MIO, ALUSrcA;
    logic [1:0]  RegDst, MemtoReg, ALUSrcB, PCSource;
    logic [2:0]  ALU_operation;
    logic [4:0]  state_out;
    logic [18:0] obs;

    int n_chk = 0;
    int n_fail = 0;
    int path[$];

    localparam logic [18:0] RST_OUTS = 19'b0000000_00_00_0_01_00_010;

    always #5 clk = ~clk;

    mcpu_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .inst_in       (inst_in),
        .zero          (zero),
        .MIO_ready     (MIO_ready),
        .PC_en         (PC_en),
        .IorD          (IorD),
        .MemRead       (MemRead),
        .MemWrite      (MemWrite),
        .IRWrite       (IRWrite),
        .RegWrite      (RegWrite),
        .CPU_MIO       (CPU_MIO),
        .RegDst        (RegDst),
        .MemtoReg      (MemtoReg),
        .ALUSrcA       (ALUSrcA),
        .ALUSrcB       (ALUSrcB),
        .PCSource      (PCSource),
        .ALU_operation (ALU_operation),
        .state_out     (state_out)
    );

    assign obs = {PC_en, IorD, MemRead, MemWrite, IRWrite, RegWrite, CPU_MIO,
                  RegDst, MemtoReg, ALUSrcA, ALUSrcB, PCSource, ALU_operation};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // {valid, alu code} for an R-type funct
    function automatic logic [3:0] r_map(input logic [5:0] f);
        case (f)
            6'h20:   return 4'b1_010;
            6'h22:   return 4'b1_110;
            6'h24:   return 4'b1_000;
            6'h25:   return 4'b1_001;
            6'h26:   return 4'b1_011;
            6'h27:   return 4'b1_100;
            6'h2a:   return 4'b1_111;
            6'h02:   return 4'b1_101;
            default: return 4'b0_010;
        endcase
    endfunction

    // expected control word in state s, packed in the same order as obs
    function automatic logic [18:0] model_out(input int s, input logic [31:0] inst, input logic z, input logic rdy);
        logic       pc, iord, mrd, mwr, irw, rw, mio, sa;
        logic [1:0] dst, m2r, sb, pcs;
        logic [2:0] alu;
        logic [3:0] r;
        r = r_map(inst[5:0]);
        {pc, iord, mrd, mwr, irw, rw, mio, sa} = '0;
        {dst, m2r, sb, pcs} = '0;
        alu = 3'b000;
        case (s)
            0:  begin mrd = 1; mio = 1; sb = 2'b01; alu = 3'b010; irw = rdy; pc = rdy; end
            1:  begin sb = 2'b11; alu = 3'b010; end
            2:  begin sa = 1; sb = 2'b10; alu = 3'b010; end
            3:  begin mrd = 1; mio = 1; iord = 1; end
            4:  begin rw = 1; m2r = 2'b01; end
            5:  begin mwr = 1; mio = 1; iord = 1; end
            6:  begin sa = 1; alu = r[2:0]; end
            7:  begin rw = r[3]; dst = 2'b01; end
            8:  begin sa = 1; alu = 3'b110; pcs = 2'b01; pc = z; end
            9:  begin sa = 1; alu = 3'b110; pcs = 2'b01; pc = ~z; end
            10: begin pc = 1; pcs = 2'b10; end
            11: begin sa = 1; sb = 2'b10; alu = (inst[31:26] == 6'b001010) ? 3'b111 : 3'b010; end
            12: rw = 1;
            13: begin pc = 1; pcs = 2'b10; rw = 1; dst = 2'b10; m2r = 2'b10; end
            default: ;
        endcase
        return {pc, iord, mrd, mwr, irw, rw, mio, dst, m2r, sa, sb, pcs, alu};
    endfunction

    // the sequence of states an instruction visits, ignoring stalls
    task automatic set_path(input logic [5:0] op);
        path = {0, 1};
        case (op)
            6'h23:        path = {0, 1, 2, 3, 4};
            6'h2b:        path = {0, 1, 2, 5};
            6'h00:        path = {0, 1, 6, 7};
            6'h04:        path = {0, 1, 8};
            6'h05:        path = {0, 1, 9};
            6'h02:        path = {0, 1, 10};
            6'h03:        path = {0, 1, 13};
            6'h08, 6'h0a: path = {0, 1, 11, 12};
            default:      ;
        endcase
    endtask

    // step one instruction through the DUT, checking every cycle; wait states repeat while not ready
    task automatic run_inst(input logic [31:0] inst, input int rd_stall, input logic z, input bit rnd);
        int i;
        int s;
        int stall;
        set_path(inst[31:26]);
        inst_in = inst;
        i = 0;
        stall = 0;
        while (i < path.size()) begin
            s = path[i];
            zero = rnd ? 1'($urandom) : z;
            MIO_ready = rnd ? ($urandom_range(0, 3) != 0) : !(s == 3 && stall < rd_stall);
            #1;
            check($sformatf("state inst=%h s=%0d", inst, s), 32'(state_out), 32'(s));
            check($sformatf("outs inst=%h s=%0d", inst, s), 32'(obs), 32'(model_out(s, inst, zero, MIO_ready)));
            if ((s == 0 || s == 3 || s == 5) && !MIO_ready)
                stall++;
            else
                i++;
            @(negedge clk);
        end
    endtask

    initial begin
        logic [5:0]  legal[9];
        logic [5:0]  fns[8];
        logic [31:0] inst;
        legal = '{6'h23, 6'h2b, 6'h00, 6'h04, 6'h05, 6'h02, 6'h03, 6'h08, 6'h0a};
        fns   = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h02};
        MIO_ready = 1'b1;
        #3;
        check("reset state", 32'(state_out), 32'd0);
        check("reset outs", 32'(obs), 32'(RST_OUTS));
        @(negedge clk);
        rst = 1'b0;
        run_inst(32'h00221820, 0, 1'b0, 1'b0);
        run_inst(32'h10220003, 0, 1'b1, 1'b0);
        run_inst(32'h10220003, 0, 1'b0, 1'b0);
        run_inst(32'h14220003, 0, 1'b0, 1'b0);
        run_inst(32'h8C220004, 2, 1'b0, 1'b0);
        run_inst(32'h0C000010, 0, 1'b0, 1'b0);
        run_inst(32'hFC000000, 0, 1'b0, 1'b0);
        run_inst(32'h0022183F, 0, 1'b0, 1'b0);
        inst_in = 32'hAC220008;
        MIO_ready = 1'b1;
        repeat (3) @(negedge clk);
        MIO_ready = 1'b0;
        #1;
        check("pre-reset state", 32'(state_out), 32'd5);
        check("pre-reset MemWrite", 32'(MemWrite), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("mid reset state", 32'(state_out), 32'd0);
        check("mid reset MemWrite", 32'(MemWrite), 32'd0);
        check("mid reset outs", 32'(obs), 32'(RST_OUTS));
        @(negedge clk);
        rst = 1'b0;
        MIO_ready = 1'b1;
        #1;
        check("resume state", 32'(state_out), 32'd0);
        check("resume outs", 32'(obs), 32'(model_out(0, inst_in, zero, 1'b1)));
        run_inst(32'h20220005, 0, 1'b0, 1'b0);
        for (int n = 0; n < 300; n++) begin
            int k;
            inst = $urandom;
            k = $urandom_range(0, 11);
            if (k < 9)
                inst[31:26] = legal[k];
            if (inst[31:26] == 6'h00 && $urandom_range(0, 1) == 1)
                inst[5:0] = fns[$urandom_range(0, 7)];
            run_inst(inst, 0, 1'b0, 1'b1);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
